nqueens_solver: RTL

Sequential backtracking solver for the N-queens problem, parametrised in board size. It places one queen per row in lexicographic column order, checks each candidate against previously placed queens one pair per cycle, backtracks on exhaustion, and reports the first solution found. It is the next generation of the 8-queen pairwise safety check: same attack rule, wrapped in a control FSM with a start/done handshake.

---
 rtl/nqueens_pkg.sv | 8 +
 rtl/nqueens_solver_if.sv | 14 +
 rtl/queen_pair_safe.sv | 18 +
 rtl/nqueens_solver.sv | 112 +++++++++++
 4 files changed

// File: rtl/nqueens_pkg.sv
// nqueens_pkg: shared FSM state enum, index-width helper and solution-counter width
package nqueens_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, NEXT, BACKTRACK, DONE} state_e;
  localparam int SOL_COUNT_W = 32;
  function automatic int max1_clog2(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/nqueens_solver_if.sv
// nqueens_solver_if: start/busy/done handshake plus found, solution and sol_count result bus
interface nqueens_solver_if import nqueens_pkg::*; #(
  parameter int N = 8,
  parameter int W = max1_clog2(N)
);
  logic start;
  logic busy;
  logic done;
  logic found;
  logic [N*W-1:0] solution;
  logic [SOL_COUNT_W-1:0] sol_count;
  modport master(output start, input busy, done, found, solution, sol_count);
  modport slave(input start, output busy, done, found, solution, sol_count);
endinterface

// File: rtl/queen_pair_safe.sv
// queen_pair_safe: combinational test that two queens (row,col) do not attack each other
module queen_pair_safe import nqueens_pkg::*; #(
  parameter int W = 3
) (
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] col_a,
  input  logic [W-1:0] row_b,
  input  logic [W-1:0] col_b,
  output logic         safe
);
  logic signed [W:0] dr, dc;
  logic [W:0] adr, adc;
  assign dr = $signed({1'b0, row_a}) - $signed({1'b0, row_b});
  assign dc = $signed({1'b0, col_a}) - $signed({1'b0, col_b});
  assign adr = dr[W] ? $unsigned(-dr) : $unsigned(dr);
  assign adc = dc[W] ? $unsigned(-dc) : $unsigned(dc);
  assign safe = !(row_a == row_b || col_a == col_b || adr == adc);
endmodule

// File: rtl/nqueens_solver.sv
// nqueens_solver: backtracking N-queens FSM with start/done handshake, COUNT_ALL_SOLUTIONS_EN counts all solutions
module nqueens_solver import nqueens_pkg::*; #(
  parameter int N = 8,
  localparam int W = max1_clog2(N)
) (
  input logic clk,
  input logic rst_n,
  nqueens_solver_if.slave bus
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_CHECK = CHECK;
  localparam logic [2:0] S_NEXT = NEXT;
  localparam logic [2:0] S_BACKTRACK = BACKTRACK;
  localparam logic [2:0] S_DONE = DONE;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] LAST = W'(N - 1);
  logic [2:0] state;
  logic [W-1:0] row, col, chk;
  logic [W-1:0] cols [N];
  logic [N*W-1:0] cand;
  logic pair_ok, accept, complete;
  queen_pair_safe #(.W(W)) u_pair (
    .row_a(row),
    .col_a(col),
    .row_b(chk),
    .col_b(cols[chk]),
    .safe (pair_ok)
  );
  for (genvar i = 0; i < N; i++) begin : g_cand
    assign cand[i*W +: W] = (i == N - 1) ? col : cols[i];
  end
  assign accept = state == S_IDLE && bus.start;
  assign complete = state == S_CHECK && chk == row && row == LAST;
  assign bus.busy = state != S_IDLE;
  assign bus.done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      row <= '0;
      col <= '0;
      chk <= '0;
      for (int r = 0; r < N; r++) cols[r] <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_CHECK;
          row <= '0;
          col <= '0;
          chk <= '0;
        end
        S_CHECK: if (chk == row) begin
          cols[row] <= col;
          if (row != LAST) begin
            row <= row + ONE;
            col <= '0;
            chk <= '0;
          end else begin
`ifdef COUNT_ALL_SOLUTIONS_EN
            state <= S_NEXT;
`else
            state <= S_DONE;
`endif
          end
        end else if (pair_ok) begin
          chk <= chk + ONE;
        end else begin
          state <= S_NEXT;
        end
        S_NEXT: if (col == LAST) begin
          state <= S_BACKTRACK;
        end else begin
          col <= col + ONE;
          chk <= '0;
          state <= S_CHECK;
        end
        S_BACKTRACK: if (row == '0) begin
          state <= S_DONE;
        end else begin
          row <= row - ONE;
          col <= cols[row - ONE];
          state <= S_NEXT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef COUNT_ALL_SOLUTIONS_EN
  logic [SOL_COUNT_W-1:0] sol_cnt;
  logic [N*W-1:0] sol_q;
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      sol_cnt <= '0;
      sol_q <= '0;
    end else if (complete) begin
      sol_cnt <= sol_cnt + 1'b1;
      sol_q <= (sol_cnt == '0) ? cand : sol_q;
    end
  end
  assign bus.found = sol_cnt != '0;
  assign bus.solution = sol_q;
  assign bus.sol_count = sol_cnt;
`else
  logic found_q;
  always_ff @(posedge clk) begin
    if (!rst_n || accept) found_q <= 1'b0;
    else if (complete) found_q <= 1'b1;
  end
  assign bus.found = found_q;
  assign bus.solution = found_q ? cand : '0;
  assign bus.sol_count = {{(SOL_COUNT_W-1){1'b0}}, found_q};
`endif
endmodule
